// File: rtl/ex_unit_mc_pkg.sv
// Shared types for the multi-cycle execute unit: ALU op codes, FSM states and
// the op-width constant used by the interface.
package ex_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_MUL   = 4'd10,
        ALU_MULHU = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } ex_state_e;

    function automatic logic is_mul_op(input logic [OP_W-1:0] op);
        return (op == ALU_MUL) || (op == ALU_MULHU);
    endfunction

endpackage

// File: rtl/ex_unit_mc_if.sv
// Issue and result bundle of the execute unit; the issuing stage is the master,
// the execute unit the slave.
interface ex_unit_mc_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic                    in_valid;
    logic                    in_ready;
    logic [XLEN-1:0]         rd1;
    logic [XLEN-1:0]         rd2;
    logic [XLEN-1:0]         immx;
    logic                    ALUSrc;
    logic [ex_pkg::OP_W-1:0] ALUControl;
    logic [TAG_W-1:0]        in_tag;
    logic                    out_valid;
    logic                    out_ready;
    logic [XLEN-1:0]         ALUResult;
    logic [XLEN-1:0]         WriteData;
    logic                    Zero;
    logic                    Sign;
    logic [TAG_W-1:0]        out_tag;

    modport master (
        output in_valid, rd1, rd2, immx, ALUSrc, ALUControl, in_tag, out_ready,
        input  in_ready, out_valid, ALUResult, WriteData, Zero, Sign, out_tag
    );

    modport slave (
        input  in_valid, rd1, rd2, immx, ALUSrc, ALUControl, in_tag, out_ready,
        output in_ready, out_valid, ALUResult, WriteData, Zero, Sign, out_tag
    );
endinterface

// File: rtl/ex_unit_mc_mul_iter.sv
// Radix-2 shift-add unsigned multiplier: one multiplier bit per cycle, XLEN steps.
// The multiplier rides in the low half of the accumulator and shifts out as the product shifts in.
module mul_iter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              start_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic              done_o,
    output logic [2*XLEN-1:0] prod_o
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN:0]     sum;

    always_comb begin
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        if (start_i) begin
            mcand_d = a_i;
            acc_d   = {{XLEN{1'b0}}, b_i};
            cnt_d   = CNT_W'(XLEN);
        end else if (cnt_q != '0) begin
            acc_d = {sum, acc_q[XLEN-1:1]};
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
        end else begin
            cnt_q   <= flush ? '0 : cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
        end
    end

    // High during the final step, so the owner can leave its busy state on the same edge.
    assign done_o = (cnt_q == CNT_W'(1));
    assign prod_o = acc_q;

endmodule

// File: rtl/ex_unit_mc.sv
// Pipelined execute stage: operand-B select, inline ALU, iterative multiplier,
// and a single registered EX/MEM output slot with valid/ready on both sides.
module ex_unit_mc
    import ex_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 5,
    parameter bit MUL_EN = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    ex_unit_mc_if.slave   bus
);
    localparam int SH_W = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_MUL  = MUL;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]        state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              zero_q, zero_d;
    logic              sign_q, sign_d;
    logic              mul_hi_q, mul_hi_d;
    logic [XLEN-1:0]   mul_wdata_q, mul_wdata_d;
    logic [TAG_W-1:0]  mul_tag_q, mul_tag_d;

    logic [XLEN-1:0]   src_b, alu_res, wr_val;
    logic [2*XLEN-1:0] mul_prod;
    logic              slot_free, accept, mul_start, mul_done, wr_single, wr_mul;

    assign src_b        = bus.ALUSrc ? bus.immx : bus.rd2;
    assign slot_free    = !out_valid_q || bus.out_ready;
    assign bus.in_ready = (state_q == S_IDLE) && slot_free && !flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign mul_start    = accept && is_mul_op(bus.ALUControl) && MUL_EN;
    assign wr_single    = accept && !mul_start;
    // flush wins over a finishing multiply: the result is dropped.
    assign wr_mul       = (state_q == S_DONE) && slot_free && !flush;

    always_comb begin
        alu_res = '0;
        case (bus.ALUControl)
            ALU_ADD:  alu_res = bus.rd1 + src_b;
            ALU_SUB:  alu_res = bus.rd1 - src_b;
            ALU_AND:  alu_res = bus.rd1 & src_b;
            ALU_OR:   alu_res = bus.rd1 | src_b;
            ALU_XOR:  alu_res = bus.rd1 ^ src_b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.rd1) < $signed(src_b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.rd1 < src_b)};
            ALU_SLL:  alu_res = bus.rd1 << src_b[SH_W-1:0];
            ALU_SRL:  alu_res = bus.rd1 >> src_b[SH_W-1:0];
            ALU_SRA:  alu_res = $unsigned($signed(bus.rd1) >>> src_b[SH_W-1:0]);
            default:  alu_res = '0;
        endcase
    end

    generate
        if (MUL_EN) begin : g_mul
            mul_iter #(.XLEN(XLEN)) u_mul (
                .clk     (clk),
                .reset   (reset),
                .flush   (flush),
                .start_i (mul_start),
                .a_i     (bus.rd1),
                .b_i     (src_b),
                .done_o  (mul_done),
                .prod_o  (mul_prod)
            );
        end else begin : g_no_mul
            assign mul_done = 1'b0;
            assign mul_prod = '0;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        mul_hi_d    = mul_hi_q;
        mul_wdata_d = mul_wdata_q;
        mul_tag_d   = mul_tag_q;
        case (state_q)
            S_IDLE: if (mul_start) begin
                state_d     = S_MUL;
                mul_hi_d    = (bus.ALUControl == ALU_MULHU);
                mul_wdata_d = bus.rd2;
                mul_tag_d   = bus.in_tag;
            end
            S_MUL:  if (mul_done) state_d = S_DONE;
            S_DONE: if (slot_free) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_val = wr_mul ? (mul_hi_q ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0]) : alu_res;

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        wdata_d     = wdata_q;
        tag_d       = tag_q;
        zero_d      = zero_q;
        sign_d      = sign_q;
        if (wr_single || wr_mul) begin
            out_valid_d = 1'b1;
            result_d    = wr_val;
            wdata_d     = wr_mul ? mul_wdata_q : bus.rd2;
            tag_d       = wr_mul ? mul_tag_q : bus.in_tag;
            zero_d      = (wr_val == '0);
            sign_d      = wr_val[XLEN-1];
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            wdata_q     <= '0;
            tag_q       <= '0;
            zero_q      <= 1'b0;
            sign_q      <= 1'b0;
            mul_hi_q    <= 1'b0;
            mul_wdata_q <= '0;
            mul_tag_q   <= '0;
        end else begin
            state_q     <= flush ? S_IDLE : state_d;
            out_valid_q <= flush ? 1'b0 : out_valid_d;
            result_q    <= result_d;
            wdata_q     <= wdata_d;
            tag_q       <= tag_d;
            zero_q      <= zero_d;
            sign_q      <= sign_d;
            mul_hi_q    <= mul_hi_d;
            mul_wdata_q <= mul_wdata_d;
            mul_tag_q   <= mul_tag_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.ALUResult = result_q;
    assign bus.WriteData = wdata_q;
    assign bus.out_tag   = tag_q;
    assign bus.Zero      = zero_q;
    assign bus.Sign      = sign_q;

endmodule

// File: tb/tb_ex_unit_mc.sv
// Bench for ex_unit_mc: directed vector table, multi-cycle corner sequences,
// then randomized traffic checked against an arithmetic reference and a result queue.
module tb_ex_unit_mc;
    import ex_pkg::*;

    localparam int XL = 32;
    localparam int TW = 5;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   total = 0;
    int   bad   = 0;

    ex_unit_mc_if #(.XLEN(XL), .TAG_W(TW)) bus ();

    ex_unit_mc #(.XLEN(XL), .TAG_W(TW), .MUL_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        src;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [31:0] wd;
        logic [4:0]  tag;
        logic        is_mul;
    } exp_t;

    vec_t vt[13];
    exp_t q[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour from the op definitions, using wide arithmetic.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [63:0] ext;
        p   = {32'b0, a} * {32'b0, b};
        ext = {{32{a[31]}}, a};
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << b[4:0];
            4'd8:  return a >> b[4:0];
            4'd9:  begin ext = ext >> b[4:0]; return ext[31:0]; end
            4'd10: return p[31:0];
            4'd11: return p[63:32];
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src, input logic [4:0] tag);
        bus.in_valid   = v;
        bus.ALUControl = op;
        bus.rd1        = a;
        bus.rd2        = b;
        bus.immx       = imm;
        bus.ALUSrc     = src;
        bus.in_tag     = tag;
    endtask

    task automatic do_mul(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input logic [4:0] tag, input logic ordy);
        int lat  = 0;
        int viol = 0;
        bus.out_ready = ordy;
        drive(1'b1, op, a, b, 32'h0, 1'b0, tag);
        #1;
        chk("mul_accept_ready", 64'(bus.in_ready), 64'd1);
        tick;
        for (int c = 1; c <= 100; c++) begin
            if (bus.in_ready) viol++;
            tick;
            if (bus.out_valid) begin
                lat = c;
                bus.in_valid = 1'b0;
                break;
            end
        end
        bus.in_valid = 1'b0;
        chk("mul_latency", 64'(lat), 64'd33);
        chk("mul_stall_in_ready", 64'(viol), 64'd0);
        chk("mul_result", 64'(bus.ALUResult), 64'(exp));
        chk("mul_tag", 64'(bus.out_tag), 64'(tag));
        chk("mul_wdata", 64'(bus.WriteData), 64'(b));
        chk("mul_sign", 64'(bus.Sign), 64'(exp[31]));
        $display("mul op=%0d a=%h b=%h res=%h latency=%0d", op, a, b, bus.ALUResult, lat);
    endtask

    task automatic abort_mul(input logic use_reset);
        int seen = 0;
        bus.out_ready = 1'b1;
        drive(1'b1, ALU_ADD, 32'h11, 32'h22, 32'h0, 1'b0, 5'd3);
        #1;
        tick;
        drive(1'b1, ALU_MUL, 32'd3, 32'd5, 32'h0, 1'b0, 5'd9);
        #1;
        chk("abort_accept", 64'(bus.in_ready), 64'd1);
        tick;
        bus.in_valid = 1'b0;
        repeat (9) tick;
        if (use_reset) reset = 1'b1;
        else           flush = 1'b1;
        #1;
        if (!use_reset) chk("flush_cycle_in_ready", 64'(bus.in_ready), 64'd0);
        tick;
        reset = 1'b0;
        flush = 1'b0;
        #1;
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        if (use_reset) begin
            chk("rst_result", 64'(bus.ALUResult), 64'd0);
            chk("rst_wdata", 64'(bus.WriteData), 64'd0);
            chk("rst_tag", 64'(bus.out_tag), 64'd0);
            chk("rst_zero", 64'(bus.Zero), 64'd0);
            chk("rst_sign", 64'(bus.Sign), 64'd0);
        end
        for (int c = 0; c < 45; c++) begin
            if (bus.out_valid) seen++;
            tick;
        end
        chk("abort_no_result", 64'(seen), 64'd0);
        $display("abort mid-mul via %s: late results seen=%0d", use_reset ? "reset" : "flush", seen);
    endtask

    initial begin
        logic [3:0]  r_op;
        logic [31:0] r_a, r_b, r_imm;
        logic        r_src;
        logic [4:0]  r_tag;
        logic        need_new;
        logic        acc, pop, mul_pend, exp_rdy;
        int          k;
        exp_t        e;

        vt[0]  = '{op: ALU_ADD,  src: 1'b1, a: 32'h0000_0010, b: 32'h0000_1234, imm: 32'hFFFF_FFF0, exp: 32'h0000_0000};
        vt[1]  = '{op: ALU_SRA,  src: 1'b0, a: 32'h8000_0000, b: 32'h0000_0021, imm: 32'h0,          exp: 32'hC000_0000};
        vt[2]  = '{op: ALU_SLT,  src: 1'b0, a: 32'hFFFF_FFFF, b: 32'h0000_0001, imm: 32'h0,          exp: 32'h0000_0001};
        vt[3]  = '{op: ALU_SLTU, src: 1'b0, a: 32'hFFFF_FFFF, b: 32'h0000_0001, imm: 32'h0,          exp: 32'h0000_0000};
        vt[4]  = '{op: ALU_SUB,  src: 1'b0, a: 32'd5,         b: 32'd7,         imm: 32'h0,          exp: 32'hFFFF_FFFE};
        vt[5]  = '{op: ALU_AND,  src: 1'b0, a: 32'hF0F0_F0F0, b: 32'h0FF0_0FF0, imm: 32'h0,          exp: 32'h00F0_00F0};
        vt[6]  = '{op: ALU_OR,   src: 1'b0, a: 32'hF0F0_F0F0, b: 32'h0FF0_0FF0, imm: 32'h0,          exp: 32'hFFF0_FFF0};
        vt[7]  = '{op: ALU_XOR,  src: 1'b0, a: 32'hF0F0_F0F0, b: 32'h0FF0_0FF0, imm: 32'h0,          exp: 32'hFF00_FF00};
        vt[8]  = '{op: ALU_SLL,  src: 1'b1, a: 32'h0000_0001, b: 32'h0000_0000, imm: 32'h0000_001F, exp: 32'h8000_0000};
        vt[9]  = '{op: ALU_SRL,  src: 1'b0, a: 32'h8000_0000, b: 32'h0000_003F, imm: 32'h0,          exp: 32'h0000_0001};
        vt[10] = '{op: 4'd12,    src: 1'b0, a: 32'd5,         b: 32'd6,         imm: 32'h0,          exp: 32'h0000_0000};
        vt[11] = '{op: 4'd15,    src: 1'b0, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, imm: 32'h0,          exp: 32'h0000_0000};
        vt[12] = '{op: ALU_ADD,  src: 1'b0, a: 32'hFFFF_FFFF, b: 32'h0000_0001, imm: 32'h0,          exp: 32'h0000_0000};

        reset = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        tick;
        tick;
        reset = 1'b0;
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_result", 64'(bus.ALUResult), 64'd0);
        chk("reset_wdata", 64'(bus.WriteData), 64'd0);
        chk("reset_zero", 64'(bus.Zero), 64'd0);
        chk("reset_sign", 64'(bus.Sign), 64'd0);
        chk("reset_tag", 64'(bus.out_tag), 64'd0);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        $display("reset state checked");

        // Back-to-back single-cycle stream: one result per cycle.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, vt[i].op, vt[i].a, vt[i].b, vt[i].imm, vt[i].src, i[4:0]);
            #1;
            chk("vec_in_ready", 64'(bus.in_ready), 64'd1);
            tick;
            chk("vec_out_valid", 64'(bus.out_valid), 64'd1);
            chk("vec_result", 64'(bus.ALUResult), 64'(vt[i].exp));
            chk("vec_zero", 64'(bus.Zero), 64'(vt[i].exp == 32'h0));
            chk("vec_sign", 64'(bus.Sign), 64'(vt[i].exp[31]));
            chk("vec_tag", 64'(bus.out_tag), 64'(i[4:0]));
            chk("vec_wdata", 64'(bus.WriteData), 64'(vt[i].b));
            $display("vec %0d op=%0d a=%h b=%h res=%h Z=%0d S=%0d", i, vt[i].op, vt[i].a, vt[i].b,
                     bus.ALUResult, bus.Zero, bus.Sign);
        end
        bus.in_valid = 1'b0;
        tick;
        chk("stream_drained", 64'(bus.out_valid), 64'd0);

        do_mul(ALU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 5'd17, 1'b1);
        tick;
        chk("mul_slot_cleared", 64'(bus.out_valid), 64'd0);
        do_mul(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd18, 1'b0);
        // Held MUL result must stay put while downstream is stalled.
        for (int c = 0; c < 4; c++) begin
            tick;
            chk("mul_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("mul_hold_result", 64'(bus.ALUResult), 64'hFFFF_FFFE);
            chk("mul_hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        tick;
        chk("mul_hold_release", 64'(bus.out_valid), 64'd0);

        // Backpressure on a single-cycle result, then release with a new op waiting.
        bus.out_ready = 1'b0;
        drive(1'b1, ALU_ADD, 32'd100, 32'd23, 32'h0, 1'b0, 5'd7);
        #1;
        chk("bp_first_ready", 64'(bus.in_ready), 64'd1);
        tick;
        drive(1'b1, ALU_SUB, 32'd50, 32'd8, 32'h0, 1'b0, 5'd8);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_result", 64'(bus.ALUResult), 64'd123);
            chk("bp_tag", 64'(bus.out_tag), 64'd7);
            tick;
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
        tick;
        bus.in_valid = 1'b0;
        chk("bp_next_result", 64'(bus.ALUResult), 64'd42);
        chk("bp_next_tag", 64'(bus.out_tag), 64'd8);
        $display("backpressure: held 123, then delivered %0d", bus.ALUResult);
        tick;
        chk("bp_cleared", 64'(bus.out_valid), 64'd0);

        abort_mul(1'b0);
        abort_mul(1'b1);

        // Randomized traffic against the reference and an in-order result queue.
        need_new = 1'b1;
        r_op = 4'd0; r_a = 32'h0; r_b = 32'h0; r_imm = 32'h0; r_src = 1'b0; r_tag = 5'd0;
        bus.in_valid = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (need_new) begin
                k = $urandom_range(0, 99);
                if (k < 5)       r_op = (k < 2) ? 4'd10 : 4'd11;
                else if (k < 12) r_op = 4'(12 + (k % 4));
                else             r_op = 4'($urandom_range(0, 9));
                r_a   = $urandom();
                r_b   = (k % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom();
                r_imm = $urandom();
                r_src = 1'($urandom_range(0, 1));
                r_tag = 5'($urandom_range(0, 31));
                drive(1'($urandom_range(0, 3) != 0), r_op, r_a, r_b, r_imm, r_src, r_tag);
                need_new = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            mul_pend = (q.size() > 0) && q[$].is_mul && !((q.size() == 1) && bus.out_valid);
            exp_rdy  = !mul_pend && (!bus.out_valid || bus.out_ready);
            chk("rnd_in_ready", 64'(bus.in_ready), 64'(exp_rdy));
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious_valid", 64'(bus.out_valid), 64'd0);
                end else begin
                    chk("rnd_result", 64'(bus.ALUResult), 64'(q[0].res));
                    chk("rnd_tag", 64'(bus.out_tag), 64'(q[0].tag));
                    chk("rnd_wdata", 64'(bus.WriteData), 64'(q[0].wd));
                    chk("rnd_zero", 64'(bus.Zero), 64'(q[0].res == 32'h0));
                    chk("rnd_sign", 64'(bus.Sign), 64'(q[0].res[31]));
                end
            end
            acc = bus.in_valid && bus.in_ready;
            pop = bus.out_valid && bus.out_ready;
            e.res    = ref_alu(r_op, r_a, r_src ? r_imm : r_b);
            e.wd     = r_b;
            e.tag    = r_tag;
            e.is_mul = (r_op == 4'd10) || (r_op == 4'd11);
            tick;
            if (pop && q.size() > 0) begin
                $display("rnd out tag=%0d res=%h", q[0].tag, q[0].res);
                void'(q.pop_front());
            end
            if (acc) begin
                q.push_back(e);
                need_new = 1'b1;
            end else if (!bus.in_valid) begin
                need_new = 1'b1;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 100 && q.size() > 0; c++) begin
            #1;
            if (bus.out_valid) begin
                chk("drain_result", 64'(bus.ALUResult), 64'(q[0].res));
                chk("drain_tag", 64'(bus.out_tag), 64'(q[0].tag));
                $display("rnd out tag=%0d res=%h", q[0].tag, q[0].res);
                void'(q.pop_front());
            end
            tick;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_unit_mc.md
Name: ex_unit_mc

Overview:
- Parametrised, pipelined successor to the single-cycle execute stage.
- Selects operand B, computes an extended ALU op set, and registers the result into an EX/MEM output slot.
- Uses a valid/ready handshake on both sides, with a pipeline flush input.
- Adds an iterative shift-add multiplier (MUL, MULHU), so the unit is multi-cycle and stalls the issue side while busy.

Parameters:
- XLEN, 32, datapath width; power of two, at least 8.
- TAG_W, 5, width of the destination-register tag carried alongside the result.
- MUL_EN, 1, 1 = multiplier present; 0 = MUL/MULHU return 0 in one cycle.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- flush  input  1  synchronous abort of in-flight op and output slot
- in_valid  input  1  operands/op presented
- in_ready  output  1  unit accepts this cycle
- rd1  input  XLEN  operand A
- rd2  input  XLEN  operand B / store data
- immx  input  XLEN  sign-extended immediate
- ALUSrc  input  1  1 = srcB is immx, 0 = srcB is rd2
- ALUControl  input  4  op code (package enum)
- in_tag  input  TAG_W  destination tag
- out_valid  output  1  output slot holds a result
- out_ready  input  1  downstream consumes
- ALUResult  output  XLEN  registered result
- WriteData  output  XLEN  registered rd2
- Zero  output  1  ALUResult == 0
- Sign  output  1  ALUResult[XLEN-1]
- out_tag  output  TAG_W  registered in_tag

Behaviour:
- Reset: out_valid=0, ALUResult=0, WriteData=0, Zero=0, Sign=0, out_tag=0, FSM=IDLE, counter=0.
- Accept condition: in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Ops:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4.
  - SLT=5 (signed) and SLTU=6 (unsigned) both produce a result of 1 or 0.
  - SLL=7, SRL=8, SRA=9 shift by srcB[log2(XLEN)-1:0] only.
  - MUL=10 gives the low XLEN bits of the unsigned product.
  - MULHU=11 gives the high XLEN bits of the unsigned product.
  - Codes 12-15 produce result 0.
- All arithmetic is modulo 2^XLEN; no overflow flag.
- Single-cycle ops: accepted at edge N, out_valid=1 with result after edge N+1 (1-cycle latency); a back-to-back stream runs at full throughput.
- FSM states:
  - IDLE: a MUL/MULHU accept (MUL_EN=1) latches multiplicand, multiplier and tag, clears the 2*XLEN accumulator, loads counter=XLEN, and moves to MUL.
  - MUL: one multiplier bit per cycle; counter decrements. When counter hits 0, go to DONE.
  - DONE: if (!out_valid || out_ready), write the selected half to the output slot and return to IDLE; otherwise wait in DONE.
  - Unblocked MUL latency is XLEN+1 cycles from accept to out_valid.
- Output slot:
  - While out_valid && !out_ready, all outputs hold stable.
  - Slot is cleared when out_ready && no new write that cycle.
  - Zero and Sign are computed from the value written into the slot.
- flush: clears out_valid and forces FSM to IDLE next edge. Data registers may keep stale values; in_ready=0 during the flush cycle. flush beats a simultaneous out_ready or MUL completion.
- reset mid-MUL: same as flush, plus all registers return to reset values.
- MUL_EN=0: MUL/MULHU behave as single-cycle ops with result 0; states MUL and DONE are unreachable.

Decomposition:
- Package ex_pkg holds:
  - alu_op_e: 4-bit enum of the codes above.
  - ex_state_e: IDLE, MUL, DONE.
  - Constant OP_W=4.
- Sub-module mul_iter (XLEN parameter) holds the accumulator, counter and start/done handshake.
- The combinational ALU stays inline in ex_unit_mc.

Test Plan:
- ADD, ALUSrc=1, rd1=0x0000_0010, immx=0xFFFF_FFF0 -> one cycle after accept: ALUResult=0, Zero=1, Sign=0.
- SRA rd1=0x8000_0000, rd2=0x0000_0021 (shamt 1) -> ALUResult=0xC000_0000, Sign=1.
- SLT 0xFFFF_FFFF vs 1 gives 1; SLTU on the same operands gives 0; issued back-to-back, they produce out_valid on consecutive cycles.
- MUL with in_valid held high:
  - MUL 7 x 0xFFFF_FFFD -> 0xFFFF_FFEB after 33 cycles, with in_ready=0 throughout.
  - MULHU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFE.
- Backpressure: out_ready=0 with the slot full -> in_ready=0, outputs stable, and a completed MUL waits in DONE. Raising out_ready delivers the old result, then the MUL result the next cycle.
- flush at cycle 10 of a MUL -> out_valid=0, in_ready=1 next cycle, and no MUL result ever appears. Repeat with reset -> all outputs 0.
